// File: rtl/fetch_redirect_ctrl_pkg.sv
// ============================================================================
// fetch_redirect_ctrl_pkg
// Shared types and defaults for the fetch redirect controller.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package fetch_redirect_ctrl_pkg;

  localparam int DEF_DEPTH        = 7;
  localparam int DEF_DRAIN_CYCLES = 4;
  localparam int DEF_CNT_W        = 16;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_SYS   = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_PRED = 2'd1,
    SRC_FIX  = 2'd2,
    SRC_SYS  = 2'd3
  } redir_src_e;

  // Instruction fetch is word aligned; low PC bits never reach IF.
  function automatic logic [31:0] align_pc(input logic [31:0] pc);
    return {pc[31:2], 2'b00};
  endfunction

endpackage

`default_nettype wire

// File: rtl/fetch_redirect_ctrl_sat_counter.sv
// ============================================================================
// sat_counter
// Up-counter with synchronous clear that sticks at its maximum value.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_inc,
  input  logic             i_clear,
  output logic [CNT_W-1:0] o_count
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (i_clear) begin
      count_d = '0;
    end else if (i_inc && (count_q != {CNT_W{1'b1}})) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign o_count = count_q;

endmodule

`default_nettype wire

// File: rtl/fetch_redirect_ctrl.sv
// ============================================================================
// fetch_redirect_ctrl
// Arbitrates PC redirects (BTB, ID fix, syscall resume), drives fetch-stage
// squash and sequences the syscall drain handshake.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_redirect_ctrl
  import fetch_redirect_ctrl_pkg::*;
#(
  parameter int DEPTH        = DEF_DEPTH,
  parameter int DRAIN_CYCLES = DEF_DRAIN_CYCLES,
  parameter int CNT_W        = DEF_CNT_W
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             STALL,
  input  logic             pred_req,
  input  logic [31:0]      pred_pc,
  input  logic             fix_req,
  input  logic [31:0]      fix_pc,
  input  logic             sys_req,
  input  logic [31:0]      sys_resume_pc,
  output logic             redirect_valid,
  output logic [31:0]      redirect_pc,
  output logic [DEPTH-1:0] FLUSH_OUT,
  output logic             fetch_hold,
  output logic             sys_ready,
  output logic [CNT_W-1:0] mispredict_cnt
);

  localparam int               DCW        = $clog2(DRAIN_CYCLES + 1);
  localparam logic [DCW-1:0]   DRAIN_INIT = DCW'(DRAIN_CYCLES);

  state_e           state_q, state_d;
  logic [DCW-1:0]   drain_cnt_q, drain_cnt_d;
  logic             redirect_valid_q, redirect_valid_d;
  logic [31:0]      redirect_pc_q, redirect_pc_d;
  logic [DEPTH-1:0] flush_q, flush_d;
  logic             fetch_hold_q, fetch_hold_d;
  logic             sys_ready_q, sys_ready_d;
  redir_src_e       src;
  logic             fix_accept;

  always_comb begin
    state_d      = state_q;
    drain_cnt_d  = drain_cnt_q;
    src          = SRC_NONE;
    flush_d      = '0;
    fetch_hold_d = 1'b0;
    sys_ready_d  = 1'b0;
    case (state_q)
      ST_RUN: begin
        // A fix wins even under STALL: the wrong-path stages must die now.
        if (fix_req) begin
          src     = SRC_FIX;
          flush_d = {DEPTH{1'b1}};
        end else if (sys_req) begin
          state_d      = ST_DRAIN;
          drain_cnt_d  = DRAIN_INIT;
          flush_d      = {DEPTH{1'b1}};
          fetch_hold_d = 1'b1;
        end else if (pred_req && !STALL) begin
          src = SRC_PRED;
        end
      end
      ST_DRAIN: begin
        fetch_hold_d = 1'b1;
        if (drain_cnt_q == '0) begin
          state_d     = ST_SYS;
          sys_ready_d = 1'b1;
        end else if (!STALL) begin
          drain_cnt_d = drain_cnt_q - DCW'(1);
        end
      end
      ST_SYS: begin
        if (!sys_req) begin
          src     = SRC_SYS;
          state_d = ST_RUN;
        end else begin
          fetch_hold_d = 1'b1;
          sys_ready_d  = 1'b1;
        end
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  always_comb begin
    redirect_valid_d = (src != SRC_NONE);
    redirect_pc_d    = redirect_pc_q;
    case (src)
      SRC_PRED: redirect_pc_d = align_pc(pred_pc);
      SRC_FIX:  redirect_pc_d = align_pc(fix_pc);
      SRC_SYS:  redirect_pc_d = align_pc(sys_resume_pc);
      default:  redirect_pc_d = redirect_pc_q;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q          <= ST_RUN;
      drain_cnt_q      <= '0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
      flush_q          <= '0;
      fetch_hold_q     <= 1'b0;
      sys_ready_q      <= 1'b0;
    end else begin
      state_q          <= state_d;
      drain_cnt_q      <= drain_cnt_d;
      redirect_valid_q <= redirect_valid_d;
      redirect_pc_q    <= redirect_pc_d;
      flush_q          <= flush_d;
      fetch_hold_q     <= fetch_hold_d;
      sys_ready_q      <= sys_ready_d;
    end
  end

  assign fix_accept = (state_q == ST_RUN) && fix_req;

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_mispredict_cnt (
    .clk     (CLK),
    .rst     (RESET),
    .i_inc   (fix_accept),
    .i_clear (RESET),
    .o_count (mispredict_cnt)
  );

  assign redirect_valid = redirect_valid_q;
  assign redirect_pc    = redirect_pc_q;
  assign FLUSH_OUT      = flush_q;
  assign fetch_hold     = fetch_hold_q;
  assign sys_ready      = sys_ready_q;

endmodule

`default_nettype wire

// File: tb/tb_fetch_redirect_ctrl.sv
// ============================================================================
// tb_fetch_redirect_ctrl
// Directed self-checking bench for fetch_redirect_ctrl.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fetch_redirect_ctrl;

  localparam int DEPTH        = 7;
  localparam int DRAIN_CYCLES = 4;
  localparam int CNT_W        = 4;

  logic             CLK;
  logic             RESET;
  logic             STALL;
  logic             pred_req;
  logic [31:0]      pred_pc;
  logic             fix_req;
  logic [31:0]      fix_pc;
  logic             sys_req;
  logic [31:0]      sys_resume_pc;
  logic             redirect_valid;
  logic [31:0]      redirect_pc;
  logic [DEPTH-1:0] FLUSH_OUT;
  logic             fetch_hold;
  logic             sys_ready;
  logic [CNT_W-1:0] mispredict_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  fetch_redirect_ctrl #(
    .DEPTH        (DEPTH),
    .DRAIN_CYCLES (DRAIN_CYCLES),
    .CNT_W        (CNT_W)
  ) dut (
    .CLK            (CLK),
    .RESET          (RESET),
    .STALL          (STALL),
    .pred_req       (pred_req),
    .pred_pc        (pred_pc),
    .fix_req        (fix_req),
    .fix_pc         (fix_pc),
    .sys_req        (sys_req),
    .sys_resume_pc  (sys_resume_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .FLUSH_OUT      (FLUSH_OUT),
    .fetch_hold     (fetch_hold),
    .sys_ready      (sys_ready),
    .mispredict_cnt (mispredict_cnt)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // fix/pred must never be presented while the fetch path is held for a syscall
  always @(posedge CLK) begin
    if (!RESET && fetch_hold && (fix_req || pred_req)) begin
      n_bad = n_bad + 1;
      $display("FAIL protocol: fix_req=%0b pred_req=%0b while fetch_hold=1", fix_req, pred_req);
    end
  end

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs;
    STALL = 1'b0; pred_req = 1'b0; fix_req = 1'b0; sys_req = 1'b0;
  endtask

  task automatic test_reset;
    RESET = 1'b1;
    tick(); tick();
    n_cmp++; if (redirect_valid !== 1'b0) begin n_bad++; $display("FAIL reset_rv: got %0b want 0", redirect_valid); end
    n_cmp++; if (redirect_pc !== 32'h0) begin n_bad++; $display("FAIL reset_pc: got %h want 0", redirect_pc); end
    n_cmp++; if (FLUSH_OUT !== 7'h00) begin n_bad++; $display("FAIL reset_flush: got %h want 00", FLUSH_OUT); end
    n_cmp++; if ({fetch_hold, sys_ready} !== 2'b00) begin n_bad++; $display("FAIL reset_hold_ready: got %b want 00", {fetch_hold, sys_ready}); end
    n_cmp++; if (mispredict_cnt !== 4'h0) begin n_bad++; $display("FAIL reset_cnt: got %h want 0", mispredict_cnt); end
    RESET = 1'b0;
  endtask

  task automatic test_pred;
    pred_req = 1'b1; pred_pc = 32'h0040_0010;
    tick();
    pred_req = 1'b0;
    n_cmp++; if (redirect_valid !== 1'b1) begin n_bad++; $display("FAIL pred_rv: got %0b want 1", redirect_valid); end
    n_cmp++; if (redirect_pc !== 32'h0040_0010) begin n_bad++; $display("FAIL pred_pc: got %h want 00400010", redirect_pc); end
    n_cmp++; if (FLUSH_OUT !== 7'h00) begin n_bad++; $display("FAIL pred_flush: got %h want 00", FLUSH_OUT); end
    tick();
    n_cmp++; if (redirect_valid !== 1'b0) begin n_bad++; $display("FAIL pred_pulse: got %0b want 0", redirect_valid); end
    // Predictions under STALL are dropped
    pred_req = 1'b1; pred_pc = 32'h0040_0020; STALL = 1'b1;
    tick();
    idle_inputs();
    n_cmp++; if (redirect_valid !== 1'b0) begin n_bad++; $display("FAIL pred_stall: got %0b want 0", redirect_valid); end
  endtask

  task automatic test_fix;
    fix_req = 1'b1; fix_pc = 32'h0040_0103;
    pred_req = 1'b1; pred_pc = 32'h0040_0999; STALL = 1'b1;
    tick();
    idle_inputs();
    n_cmp++; if (redirect_valid !== 1'b1) begin n_bad++; $display("FAIL fix_rv: got %0b want 1", redirect_valid); end
    n_cmp++; if (redirect_pc !== 32'h0040_0100) begin n_bad++; $display("FAIL fix_pc: got %h want 00400100", redirect_pc); end
    n_cmp++; if (FLUSH_OUT !== 7'h7F) begin n_bad++; $display("FAIL fix_flush: got %h want 7f", FLUSH_OUT); end
    n_cmp++; if (mispredict_cnt !== 4'h1) begin n_bad++; $display("FAIL fix_cnt: got %h want 1", mispredict_cnt); end
    tick();
    n_cmp++; if ({redirect_valid, FLUSH_OUT} !== 8'h00) begin n_bad++; $display("FAIL fix_after: got %h want 00", {redirect_valid, FLUSH_OUT}); end
  endtask

  task automatic test_sys_drain;
    logic [6:0] stall_pat;
    stall_pat = 7'b0000110;
    // fix and sys together: fix first, sys next cycle
    fix_req = 1'b1; fix_pc = 32'h0040_0300; sys_req = 1'b1;
    tick();
    fix_req = 1'b0;
    n_cmp++; if ({redirect_valid, redirect_pc} !== {1'b1, 32'h0040_0300}) begin n_bad++; $display("FAIL fixsys_first: got %b/%h want 1/00400300", redirect_valid, redirect_pc); end
    n_cmp++; if ({fetch_hold, mispredict_cnt} !== {1'b0, 4'h2}) begin n_bad++; $display("FAIL fixsys_hold_cnt: got %b/%h want 0/2", fetch_hold, mispredict_cnt); end
    tick();
    n_cmp++; if ({redirect_valid, FLUSH_OUT, fetch_hold, sys_ready} !== {1'b0, 7'h7F, 1'b1, 1'b0}) begin n_bad++; $display("FAIL drain_entry: got rv=%b fl=%h h=%b r=%b want 0/7f/1/0", redirect_valid, FLUSH_OUT, fetch_hold, sys_ready); end
    for (int k = 1; k <= 7; k++) begin
      STALL = stall_pat[k-1];
      tick();
      n_cmp++;
      if ({fetch_hold, FLUSH_OUT, redirect_valid, sys_ready} !== {1'b1, 7'h00, 1'b0, (k == 7)}) begin
        n_bad++;
        $display("FAIL drain_k%0d: got h=%b fl=%h rv=%b r=%b want 1/00/0/%0b", k, fetch_hold, FLUSH_OUT, redirect_valid, sys_ready, (k == 7));
      end
    end
    STALL = 1'b0;
  endtask

  task automatic test_sys_resume;
    tick();
    n_cmp++; if ({fetch_hold, sys_ready} !== 2'b11) begin n_bad++; $display("FAIL sys_hold: got %b want 11", {fetch_hold, sys_ready}); end
    sys_req = 1'b0; sys_resume_pc = 32'h0040_0200;
    tick();
    n_cmp++; if ({redirect_valid, redirect_pc} !== {1'b1, 32'h0040_0200}) begin n_bad++; $display("FAIL resume_redir: got %b/%h want 1/00400200", redirect_valid, redirect_pc); end
    n_cmp++; if ({fetch_hold, sys_ready, FLUSH_OUT} !== 9'h000) begin n_bad++; $display("FAIL resume_outs: got %h want 000", {fetch_hold, sys_ready, FLUSH_OUT}); end
    tick();
    n_cmp++; if (redirect_valid !== 1'b0) begin n_bad++; $display("FAIL resume_pulse: got %0b want 0", redirect_valid); end
    pred_req = 1'b1; pred_pc = 32'h0040_0404;
    tick();
    pred_req = 1'b0;
    n_cmp++; if ({redirect_valid, redirect_pc} !== {1'b1, 32'h0040_0404}) begin n_bad++; $display("FAIL resume_run: got %b/%h want 1/00400404", redirect_valid, redirect_pc); end
  endtask

  task automatic test_reset_in_drain;
    sys_req = 1'b1;
    tick(); tick(); tick();
    n_cmp++; if (fetch_hold !== 1'b1) begin n_bad++; $display("FAIL rdrain_pre: got %0b want 1", fetch_hold); end
    RESET = 1'b1; sys_req = 1'b0;
    tick();
    RESET = 1'b0;
    n_cmp++; if ({redirect_valid, redirect_pc, FLUSH_OUT, fetch_hold, sys_ready, mispredict_cnt} !== 46'h0) begin n_bad++; $display("FAIL rdrain_zero: rv=%b pc=%h fl=%h h=%b r=%b c=%h want all 0", redirect_valid, redirect_pc, FLUSH_OUT, fetch_hold, sys_ready, mispredict_cnt); end
    pred_req = 1'b1; pred_pc = 32'h0040_0500;
    tick();
    pred_req = 1'b0;
    n_cmp++; if ({redirect_valid, redirect_pc, FLUSH_OUT} !== {1'b1, 32'h0040_0500, 7'h00}) begin n_bad++; $display("FAIL rdrain_pred: got %b/%h/%h want 1/00400500/00", redirect_valid, redirect_pc, FLUSH_OUT); end
  endtask

  task automatic test_saturation;
    fix_pc = 32'h0040_0600;
    for (int i = 0; i < 19; i++) begin
      fix_req = 1'b1;
      tick();
      if (i == 13) begin
        n_cmp++; if (mispredict_cnt !== 4'hE) begin n_bad++; $display("FAIL sat_14: got %h want e", mispredict_cnt); end
      end
      if (i == 14) begin
        n_cmp++; if (mispredict_cnt !== 4'hF) begin n_bad++; $display("FAIL sat_15: got %h want f", mispredict_cnt); end
      end
    end
    fix_req = 1'b0;
    tick();
    n_cmp++; if (mispredict_cnt !== 4'hF) begin n_bad++; $display("FAIL sat_hold: got %h want f", mispredict_cnt); end
  endtask

  initial begin
    RESET = 1'b1; idle_inputs();
    pred_pc = '0; fix_pc = '0; sys_resume_pc = '0;
    test_reset();
    test_pred();
    test_fix();
    test_sys_drain();
    test_sys_resume();
    test_reset_in_drain();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
